// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS core: sequences the shared datapath
// through fetch/decode/execute/memory/write-back and counts retired instructions.
module mips_multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Opcode,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        BranchNE,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        ExtOp,
  output logic [2:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic        IllegalOp,
  output logic [31:0] InstrCount
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
    R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                         OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_LUI  = 6'h0F,
                         OP_LW    = 6'h23, OP_SW   = 6'h2B;

  state_t state, nextState;
  logic   retire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      InstrCount <= 32'd0;
    else if (retire) InstrCount <= InstrCount + 32'd1;
  end

  always_comb begin
    nextState   = state;
    retire      = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNE    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 2'b00;
    MemtoReg    = 2'b00;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ExtOp       = 1'b0;
    ALUOp       = 3'b000;
    PCSource    = 2'b00;
    IllegalOp   = 1'b0;
    case (state)
      IDLE: nextState = FETCH;
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // IR and PC+4 commit only in the cycle memory delivers the word
        if (MemReady) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          nextState = DECODE;
        end
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW:                  nextState = MEM_ADDR;
          OP_RTYPE:                      nextState = R_EXEC;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: nextState = I_EXEC;
          OP_BEQ, OP_BNE:                nextState = BRANCH;
          OP_J, OP_JAL:                  nextState = JUMP;
          default: begin
            IllegalOp = 1'b1;
            nextState = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        nextState = (Opcode == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady) nextState = MEM_WB;
      end
      MEM_WB: begin
        RegWrite  = 1'b1;
        MemtoReg  = 2'b01;
        retire    = 1'b1;
        nextState = FETCH;
      end
      MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady) begin
          retire    = 1'b1;
          nextState = FETCH;
        end
      end
      R_EXEC: begin
        ALUSrcA   = 1'b1;
        ALUOp     = 3'b010;
        nextState = R_WB;
      end
      R_WB: begin
        RegWrite  = 1'b1;
        RegDst    = 2'b01;
        retire    = 1'b1;
        nextState = FETCH;
      end
      I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (Opcode)
          OP_ANDI: begin ExtOp = 1'b1; ALUOp = 3'b100; end
          OP_ORI:  begin ExtOp = 1'b1; ALUOp = 3'b011; end
          OP_LUI:  ALUOp = 3'b101;
          default: ALUOp = 3'b000;
        endcase
        nextState = I_WB;
      end
      I_WB: begin
        RegWrite  = 1'b1;
        retire    = 1'b1;
        nextState = FETCH;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 3'b001;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        BranchNE    = (Opcode == OP_BNE);
        retire      = 1'b1;
        nextState   = FETCH;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        // jal links the return address (PC+4 already in PC) into $31
        if (Opcode == OP_JAL) begin
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          MemtoReg = 2'b10;
        end
        retire    = 1'b1;
        nextState = FETCH;
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: walks each instruction class
// cycle by cycle and compares the full control word and retire counter.
module tb_mips_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  Opcode;
  logic        MemReady;
  logic        PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
  logic        RegWrite, ALUSrcA, ExtOp, IllegalOp;
  logic [2:0]  ALUOp;
  logic [31:0] InstrCount;

  int nChecks = 0;
  int nBad = 0;

  mips_multicycle_control dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .ALUOp(ALUOp),
    .PCSource(PCSource), .IllegalOp(IllegalOp), .InstrCount(InstrCount)
  );

  always #5 clk = ~clk;

  logic [21:0] ctl;
  assign ctl = {PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite,
                RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ExtOp, ALUOp,
                PCSource, IllegalOp};

  // Control word in the same field order as ctl above
  function automatic logic [21:0] cw(
    input logic pcw, input logic pcwc, input logic bne, input logic iord,
    input logic mr, input logic mw, input logic irw, input logic [1:0] rd,
    input logic [1:0] m2r, input logic rw, input logic sa, input logic [1:0] sb,
    input logic ext, input logic [2:0] op, input logic [1:0] pcs, input logic ill);
    return {pcw, pcwc, bne, iord, mr, mw, irw, rd, m2r, rw, sa, sb, ext, op, pcs, ill};
  endfunction

  logic [21:0] cIdle, cFetch, cFetchWait, cDec, cDecIll, cMemAddr, cMemRd, cMemWb,
               cMemWr, cRExec, cRWb, cOri, cIWb, cBne, cJal;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at posedge+1 with inputs already applied; checks, then advances a cycle
  task automatic stepChk(input string tag, input logic [21:0] exp);
    #1;
    check(tag, {10'd0, ctl}, {10'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    //           pcw pcwc bne iord mr mw irw rd    m2r   rw sa sb    ext op      pcs   ill
    cIdle      = '0;
    cFetch     = cw(1, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 0, 0, 2'b01, 0, 3'b000, 2'b00, 0);
    cFetchWait = cw(0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b01, 0, 3'b000, 2'b00, 0);
    cDec       = cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b11, 0, 3'b000, 2'b00, 0);
    cDecIll    = cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b11, 0, 3'b000, 2'b00, 1);
    cMemAddr   = cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 0, 3'b000, 2'b00, 0);
    cMemRd     = cw(0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 3'b000, 2'b00, 0);
    cMemWb     = cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 1, 0, 2'b00, 0, 3'b000, 2'b00, 0);
    cMemWr     = cw(0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 3'b000, 2'b00, 0);
    cRExec     = cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 0, 3'b010, 2'b00, 0);
    cRWb       = cw(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 1, 0, 2'b00, 0, 3'b000, 2'b00, 0);
    cOri       = cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 1, 3'b011, 2'b00, 0);
    cIWb       = cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 0, 3'b000, 2'b00, 0);
    cBne       = cw(0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 0, 3'b001, 2'b01, 0);
    cJal       = cw(1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 1, 0, 2'b00, 0, 3'b000, 2'b10, 0);

    reset = 1'b0; MemReady = 1'b1; Opcode = 6'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", {10'd0, ctl}, 32'd0);
    check("rst_cnt", InstrCount, 32'd0);
    reset = 1'b1;

    // R-type
    stepChk("r_idle", cIdle);
    stepChk("r_fetch", cFetch);
    stepChk("r_dec", cDec);
    stepChk("r_exec", cRExec);
    stepChk("r_wb", cRWb);
    check("r_cnt", InstrCount, 32'd1);

    // lw with one fetch wait and two MEM_RD waits
    Opcode = 6'h23; MemReady = 1'b0;
    stepChk("lw_fwait", cFetchWait);
    MemReady = 1'b1;
    stepChk("lw_fetch", cFetch);
    stepChk("lw_dec", cDec);
    stepChk("lw_addr", cMemAddr);
    MemReady = 1'b0;
    stepChk("lw_rd_w0", cMemRd);
    stepChk("lw_rd_w1", cMemRd);
    MemReady = 1'b1;
    stepChk("lw_rd", cMemRd);
    check("lw_cnt_pre", InstrCount, 32'd1);
    stepChk("lw_wb", cMemWb);
    check("lw_cnt", InstrCount, 32'd2);

    // bne
    Opcode = 6'h05;
    stepChk("bne_fetch", cFetch);
    stepChk("bne_dec", cDec);
    stepChk("bne_br", cBne);
    check("bne_cnt", InstrCount, 32'd3);

    // ori
    Opcode = 6'h0D;
    stepChk("ori_fetch", cFetch);
    stepChk("ori_dec", cDec);
    stepChk("ori_exec", cOri);
    stepChk("ori_wb", cIWb);
    check("ori_cnt", InstrCount, 32'd4);

    // jal
    Opcode = 6'h03;
    stepChk("jal_fetch", cFetch);
    stepChk("jal_dec", cDec);
    stepChk("jal_jump", cJal);
    check("jal_cnt", InstrCount, 32'd5);

    // illegal opcode: one-cycle pulse, no retire
    Opcode = 6'h3F;
    stepChk("ill_fetch", cFetch);
    stepChk("ill_dec", cDecIll);
    Opcode = 6'h2B;
    stepChk("ill_back", cFetch);
    check("ill_cnt", InstrCount, 32'd5);

    // sw completing after one wait
    stepChk("sw_dec", cDec);
    stepChk("sw_addr", cMemAddr);
    MemReady = 1'b0;
    stepChk("sw_wr_w", cMemWr);
    MemReady = 1'b1;
    stepChk("sw_wr", cMemWr);
    check("sw_cnt", InstrCount, 32'd6);

    // sw interrupted by reset during the write wait
    stepChk("swr_fetch", cFetch);
    stepChk("swr_dec", cDec);
    stepChk("swr_addr", cMemAddr);
    MemReady = 1'b0;
    #1;
    check("swr_wr", {10'd0, ctl}, {10'd0, cMemWr});
    reset = 1'b0;
    #1;
    check("swr_rst_ctl", {10'd0, ctl}, 32'd0);
    check("swr_rst_cnt", InstrCount, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1; MemReady = 1'b1;
    stepChk("swr_idle", cIdle);
    stepChk("swr_refetch", cFetch);

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Main control unit for the multicycle MIPS core: a Moore/Mealy state machine that sequences the shared datapath (PC, instruction register, unified memory, register file, single ALU) through fetch, decode, execute, memory and write-back steps. It sits beside the datapath inside the processor top, takes the current opcode and a memory-ready handshake, and drives every datapath enable and mux select. It also counts retired instructions and flags unsupported opcodes.

## Interface
- No parameters; opcode encodings are fixed MIPS-I values.
- clk  input  1  core clock, rising-edge active
- reset  input  1  asynchronous, active-low; state forced to IDLE while low
- Opcode  input  6  IR[31:26], valid from DECODE onward
- MemReady  input  1  memory completes the current access this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if branch condition true
- BranchNE  output  1  0: condition is Zero, 1: condition is !Zero
- IorD  output  1  memory address mux: 0 PC, 1 ALUOut
- MemRead / MemWrite  output  1 each  memory strobes
- IRWrite  output  1  instruction register load
- RegDst  output  2  00 rt, 01 rd, 10 $31
- MemtoReg  output  2  00 ALUOut, 01 MDR, 10 PC
- RegWrite  output  1  register-file write
- ALUSrcA  output  1  0 PC, 1 A
- ALUSrcB  output  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
- ExtOp  output  1  0 sign-extend, 1 zero-extend
- ALUOp  output  3  000 add, 001 sub, 010 funct, 011 or, 100 and, 101 lui
- PCSource  output  2  00 ALU, 01 ALUOut, 10 jump target
- IllegalOp  output  1  one-cycle pulse on unsupported opcode
- InstrCount  output  32  retired-instruction counter

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
- IDLE: all outputs 0; unconditional -> FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00; IRWrite and PCWrite asserted only when MemReady=1 (Mealy). Stay until MemReady=1, then -> DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000 (branch target into ALUOut). Next by Opcode: 0x23/0x2B -> MEM_ADDR; 0x00 -> R_EXEC; 0x08/0x0C/0x0D/0x0F -> I_EXEC; 0x04/0x05 -> BRANCH; 0x02/0x03 -> JUMP; otherwise IllegalOp=1, -> FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ExtOp=0, ALUOp=000; lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: MemRead=1, IorD=1; hold until MemReady, -> MEM_WB.
- MEM_WB: RegWrite=1, RegDst=00, MemtoReg=01; -> FETCH.
- MEM_WR: MemWrite=1, IorD=1; hold until MemReady, -> FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010; -> R_WB: RegWrite=1, RegDst=01, MemtoReg=00; -> FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10; addi: ExtOp=0, ALUOp=000; andi: ExtOp=1, ALUOp=100; ori: ExtOp=1, ALUOp=011; lui: ALUOp=101. -> I_WB: RegWrite=1, RegDst=00, MemtoReg=00; -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01, BranchNE=(Opcode==0x05); -> FETCH.
- JUMP: PCWrite=1, PCSource=10; jal additionally RegWrite=1, RegDst=10, MemtoReg=10; -> FETCH.
- Any signal not listed for a state is 0.
- InstrCount increments by 1 on the clock edge leaving MEM_WB, MEM_WR (with MemReady), R_WB, I_WB, BRANCH, JUMP; wraps 0xFFFFFFFF -> 0. Illegal opcodes do not count.

## Timing
- Reset low (any time, mid-instruction included): state=IDLE, InstrCount=0, all outputs 0 immediately; no memory strobe survives reset.
- First rising edge after reset release -> FETCH; second memory-strobe cycle possible only after MemReady.
- Latency with MemReady tied 1: beq/bne 3, j/jal 3, R-type 4, I-type 4, sw 4, lw 5 cycles; each memory wait adds one cycle in FETCH, MEM_RD or MEM_WR.
- MemRead/MemWrite remain asserted and stable for every wait cycle; IRWrite/PCWrite never assert while MemReady=0.
- Opcode is sampled only in DECODE and MEM_ADDR/I_EXEC/BRANCH/JUMP; IR is stable there since IRWrite=0.
- Outputs combinational from state (plus MemReady in FETCH); no output glitches from Opcode outside decode-dependent states.

## Test plan
- Reset held low 3 cycles, released with MemReady=1, Opcode=0x00 -> IDLE, FETCH, DECODE, R_EXEC, R_WB, FETCH; InstrCount=1; RegWrite only in R_WB with RegDst=01.
- lw (0x23) with MemReady low 2 cycles in MEM_RD -> MemRead/IorD=1 held 3 cycles, MEM_WB then RegWrite=1, MemtoReg=01; total 7 cycles.
- bne (0x05) -> BRANCH shows PCWriteCond=1, BranchNE=1, ALUOp=001, PCSource=01; ori (0x0D) -> ExtOp=1, ALUOp=011.
- jal (0x03) -> JUMP with PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10; InstrCount+1.
- Opcode 0x3F -> IllegalOp pulses 1 cycle in DECODE, back to FETCH, InstrCount unchanged.
- Reset asserted during MEM_WR wait -> MemWrite drops to 0 immediately, InstrCount=0, restart from IDLE.
